// File: rtl/pattern_detector_if.sv
// Bus bundle for pattern_detector: pattern configuration, serial data
// stream, counter clear, and the detector's match/count outputs.
// The master side drives configuration and data; the slave side is the detector.
interface pattern_detector_if #(
  parameter int MAX_LEN   = 8,
  parameter int CNT_WIDTH = 8
);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  // Configuration capture
  logic                 load;
  logic [MAX_LEN-1:0]   pattern_in;
  logic [LEN_W-1:0]     len_in;
  logic                 overlap_in;

  // Serial data stream
  logic                 enable;
  logic                 serial_in;

  // Counter control
  logic                 clear_count;

  // Detector results
  logic                 match;
  logic [CNT_WIDTH-1:0] match_count;
  logic                 count_sat;

  modport master (
    output load, pattern_in, len_in, overlap_in,
    output enable, serial_in, clear_count,
    input  match, match_count, count_sat
  );

  modport slave (
    input  load, pattern_in, len_in, overlap_in,
    input  enable, serial_in, clear_count,
    output match, match_count, count_sat
  );
endinterface

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with a programmable pattern of 1..MAX_LEN bits.
// The first pattern bit received is pattern[len-1]; the last is pattern[0].
// match is a Mealy output raised on the cycle of the completing bit; it depends
// combinationally only on enable, load and serial_in plus registered state.
// A saturating counter tallies matches and can be cleared synchronously.
module pattern_detector #(
  parameter int MAX_LEN   = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  pattern_detector_if.slave bus
);

  localparam int               LEN_W    = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  // Saturating increment of the history fill level.
  function automatic logic [LEN_W-1:0] fill_inc(input logic [LEN_W-1:0] f);
    logic [LEN_W-1:0] r;
    if (f < FILL_MAX) begin
      r = f + LEN_ONE;
    end else begin
      r = FILL_MAX;
    end
    return r;
  endfunction

  // True when the programmed length can ever produce a match.
  function automatic logic len_ok(input logic [LEN_W-1:0] l);
    return (l != {LEN_W{1'b0}}) && (l <= LEN_MAX);
  endfunction

  // Configuration registers
  logic [MAX_LEN-1:0]   pat_q,   pat_d;
  logic [LEN_W-1:0]     len_q,   len_d;
  logic                 ovl_q,   ovl_d;

  // Bit history (newest bit at [0]) and count of valid history bits
  logic [MAX_LEN-2:0]   hist_q,  hist_d;
  logic [LEN_W-1:0]     fill_q,  fill_d;

  // Match counter
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 sat_q,   sat_d;

  // Datapath signals
  logic [MAX_LEN-1:0]   window_s;
  logic [MAX_LEN-1:0]   mask_s;
  logic [MAX_LEN-1:0]   shifted_s;
  logic                 len_valid_s;
  logic                 fill_ok_s;
  logic                 window_eq_s;
  logic                 match_s;

  // Compare the newest len bits (history plus the current bit) against the pattern
  always_comb begin
    window_s  = {hist_q, bus.serial_in};
    shifted_s = {hist_q, bus.serial_in};
    mask_s    = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end
    len_valid_s = len_ok(len_q);
    // len-1 underflows when len is 0, but len_valid_s masks that case.
    fill_ok_s   = (fill_q >= (len_q - LEN_ONE));
    window_eq_s = (((window_s ^ pat_q) & mask_s) == {MAX_LEN{1'b0}});
    if (bus.enable && !bus.load && len_valid_s && fill_ok_s && window_eq_s) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Next-state for configuration, history and fill level
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (bus.load) begin
      // Load wins over enable; the concurrent serial bit is dropped.
      pat_d  = bus.pattern_in;
      len_d  = bus.len_in;
      ovl_d  = bus.overlap_in;
      hist_d = {(MAX_LEN-1){1'b0}};
      fill_d = {LEN_W{1'b0}};
    end else if (bus.enable) begin
      hist_d = shifted_s[MAX_LEN-2:0];
      if (!len_valid_s) begin
        // An unusable length never accumulates history.
        fill_d = {LEN_W{1'b0}};
      end else if (match_s && !ovl_q) begin
        // Non-overlapping mode: bits of this match cannot seed the next one.
        fill_d = {LEN_W{1'b0}};
      end else begin
        fill_d = fill_inc(fill_q);
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // Next-state for the saturating match counter; clear beats a concurrent match
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (bus.clear_count) begin
      count_d = {CNT_WIDTH{1'b0}};
      sat_d   = 1'b0;
    end else if (match_s) begin
      if (count_q == {CNT_WIDTH{1'b1}}) begin
        count_d = count_q;
        sat_d   = 1'b1;
      end else begin
        count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        sat_d   = sat_q;
      end
    end else begin
      count_d = count_q;
      sat_d   = sat_q;
    end
  end

  // Configuration and history registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pat_q  <= {MAX_LEN{1'b0}};
      len_q  <= {LEN_W{1'b0}};
      ovl_q  <= 1'b0;
      hist_q <= {(MAX_LEN-1){1'b0}};
      fill_q <= {LEN_W{1'b0}};
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  // Match counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= {CNT_WIDTH{1'b0}};
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.match       = match_s;
  assign bus.match_count = count_q;
  assign bus.count_sat   = sat_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector (MAX_LEN=8, CNT_WIDTH=2).
// Each step pushes its expected match/count/sat onto a scoreboard queue;
// the entry is popped and compared when the DUT output is sampled.
module tb_pattern_detector;

  localparam int MAX_LEN   = 8;
  localparam int CNT_WIDTH = 2;

  typedef struct packed {
    logic       m;
    logic [1:0] cnt;
    logic       sat;
  } exp_t;

  logic clk;
  logic n_rst;

  pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_WIDTH(CNT_WIDTH)) bus ();

  pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  exp_t       sb_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_cnt  = 2'd0;
  logic       exp_sat  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic ld, input logic en, input logic b,
                      input logic clr, input logic exp_m, input string tag);
    exp_t e;
    exp_t got;
    string t;
    bus.load        = ld;
    bus.enable      = en;
    bus.serial_in   = b;
    bus.clear_count = clr;
    if (clr) begin
      exp_cnt = 2'd0;
      exp_sat = 1'b0;
    end else if (exp_m) begin
      if (exp_cnt == 2'b11) exp_sat = 1'b1;
      else exp_cnt = exp_cnt + 2'd1;
    end
    e.m = exp_m; e.cnt = exp_cnt; e.sat = exp_sat;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got = sb_q.pop_front();
    t   = tag_q.pop_front();
    chk({t, " match"}, {31'd0, bus.match}, {31'd0, got.m});
    @(posedge clk);
    #1;
    chk({t, " count"}, {30'd0, bus.match_count}, {30'd0, got.cnt});
    chk({t, " sat"}, {31'd0, bus.count_sat}, {31'd0, got.sat});
    bus.load        = 1'b0;
    bus.clear_count = 1'b0;
  endtask

  // Load a pattern; enable/serial are active to show load priority; count cleared.
  task automatic load_pat(input logic [7:0] p, input logic [3:0] l, input logic o,
                          input string tag);
    bus.pattern_in = p;
    bus.len_in     = l;
    bus.overlap_in = o;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, tag);
  endtask

  // Feed n enabled bits, bits[n-1] first; exp holds expected match per bit.
  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] exp,
                        input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, bits[i], 1'b0, exp[i], $sformatf("%s bit%0d", tag, n - i));
    end
  endtask

  initial begin
    n_rst           = 1'b0;
    bus.load        = 1'b0;
    bus.pattern_in  = 8'h00;
    bus.len_in      = 4'd0;
    bus.overlap_in  = 1'b0;
    bus.enable      = 1'b1;
    bus.serial_in   = 1'b1;
    bus.clear_count = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset match", {31'd0, bus.match}, 32'd0);
    chk("reset count", {30'd0, bus.match_count}, 32'd0);
    chk("reset sat", {31'd0, bus.count_sat}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // No valid pattern after reset
    stream(16'h000F, 4, 16'h0000, "postreset");

    // Overlapping: 1101 in 1101101 -> bits 4 and 7
    load_pat(8'h0D, 4'd4, 1'b1, "ld_ovl");
    stream(16'h006D, 7, 16'h0009, "ovl");

    // Non-overlapping: bit 4 only, then 10-bit stream -> bits 4 and 10
    load_pat(8'h0D, 4'd4, 1'b0, "ld_novl");
    stream(16'h006D, 7, 16'h0008, "novl7");
    load_pat(8'h0D, 4'd4, 1'b0, "ld_novl2");
    stream(16'h036D, 10, 16'h0041, "novl10");

    // Enable gaps hold history; idle cycles present a matching bit
    load_pat(8'h0D, 4'd4, 1'b1, "ld_gap");
    stream(16'h0006, 3, 16'h0000, "gap_pre");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "gap_idle");
    stream(16'h0001, 1, 16'h0001, "gap_last");

    // Load concurrent with a completing bit: no match, history cleared
    load_pat(8'h0D, 4'd4, 1'b1, "ld_mid");
    stream(16'h0006, 3, 16'h0000, "mid_pre");
    load_pat(8'h0D, 4'd4, 1'b1, "reload");
    stream(16'h000D, 4, 16'h0001, "mid_post");

    // Invalid length above MAX_LEN never matches
    load_pat(8'h01, 4'd9, 1'b1, "ld_len9");
    stream(16'h00FF, 8, 16'h0000, "len9");

    // Asynchronous reset mid-sequence
    load_pat(8'h0D, 4'd4, 1'b1, "ld_rst");
    stream(16'h0036, 6, 16'h0004, "rst_pre");
    bus.enable    = 1'b1;
    bus.serial_in = 1'b1;
    n_rst = 1'b0;
    #2;
    chk("async rst match", {31'd0, bus.match}, 32'd0);
    chk("async rst count", {30'd0, bus.match_count}, 32'd0);
    exp_cnt = 2'd0;
    exp_sat = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    stream(16'h0001, 1, 16'h0000, "rst_nolen");
    load_pat(8'h0D, 4'd4, 1'b1, "ld_rst2");
    stream(16'h000D, 4, 16'h0001, "rst_post");

    // len=1 with saturating 2-bit counter, then clear coincident with a match
    load_pat(8'h01, 4'd1, 1'b1, "ld_sat");
    stream(16'h001F, 5, 16'h001F, "sat");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "clr_on_match");

    // Full-length pattern twice, then length 0 disables matching
    load_pat(8'hB3, 4'd8, 1'b1, "ld_full");
    stream(16'hB3B3, 16, 16'h0101, "full");
    load_pat(8'hB3, 4'd0, 1'b1, "ld_len0");
    stream(16'h00B3, 8, 16'h0000, "len0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
